// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//   state_e        : converter FSM states
//   BCD_ERR_NIBBLE : nibble driven on every digit when the value is out of range
//   add3_adj()     : double-dabble nibble correction (>=5 gets +3)
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ERR_NIBBLE = 4'hF;

    // Only called on nibbles 0..9, so the result never exceeds 4'hC (no carry).
    function automatic logic [3:0] add3_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle for bin2bcd_seq.
//   start, bin_in         : request side (master drives)
//   busy, done, bcd_out,
//   overflow              : result side (converter drives)
//   blank_mask            : present only when LEADING_ZERO_MASK_EN is defined
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
`ifdef LEADING_ZERO_MASK_EN
    logic [DIGITS-1:0]     blank_mask;
`endif

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
`ifdef LEADING_ZERO_MASK_EN
        , input blank_mask
`endif
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output overflow
`ifdef LEADING_ZERO_MASK_EN
        , output blank_mask
`endif
    );

endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// Combinational per-digit double-dabble correction.
//   nib_i : current BCD scratch nibble
//   nib_o : nibble after the conditional +3
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    assign nib_o = add3_adj(nib_i);
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bin2bcd_seq_if slave (start/bin_in in; busy/done/bcd_out/overflow out)
// Optional feature macro: LEADING_ZERO_MASK_EN adds bus.blank_mask (leading-zero blanking).
//
// state | meaning
// IDLE  | waiting for start; result outputs hold last conversion
// SHIFT | BIN_W cycles of add-3 then shift of {scratch, shift}
// LOAD  | publish scratch (or error glyphs) and pulse done
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int               SCR_W     = 4 * DIGITS;
    localparam int               CNT_W     = $clog2(BIN_W + 1);
    localparam int               MAX_VAL   = 10**DIGITS - 1;
    localparam logic [BIN_W-1:0] MAX_VAL_B = BIN_W'(MAX_VAL);

    state_e              state_q, state_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [SCR_W-1:0]    scratch_q, scratch_d;
    logic [SCR_W-1:0]    scratch_adj;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [SCR_W-1:0]    bcd_q, bcd_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib_i (scratch_q[4*g +: 4]),
            .nib_o (scratch_adj[4*g +: 4])
        );
    end

`ifdef LEADING_ZERO_MASK_EN
    localparam logic [DIGITS-1:0] MASK_RST = ~(DIGITS'(1));
    logic [DIGITS-1:0] mask_q, mask_d, mask_calc;
    logic              upper_zero;

    // Walk down from the top digit; a digit is blankable only if it and every
    // digit above it are zero. The units digit is never blanked.
    always_comb begin
        mask_calc  = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero   = upper_zero && (scratch_q[4*i +: 4] == 4'd0);
            mask_calc[i] = upper_zero;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
`ifdef LEADING_ZERO_MASK_EN
        mask_d     = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.bin_in;
                    scratch_d = '0;
                    count_d   = CNT_W'(BIN_W);
                    ovf_d     = (bus.bin_in > MAX_VAL_B);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d      = ovf_q ? {DIGITS{BCD_ERR_NIBBLE}} : scratch_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
`ifdef LEADING_ZERO_MASK_EN
                mask_d     = ovf_q ? '0 : mask_calc;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef LEADING_ZERO_MASK_EN
            mask_q     <= MASK_RST;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
`ifdef LEADING_ZERO_MASK_EN
            mask_q     <= mask_d;
`endif
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = overflow_q;
`ifdef LEADING_ZERO_MASK_EN
    assign bus.blank_mask = mask_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed + random checks for bin2bcd_seq (default BIN_W=14, DIGITS=4).
module tb_bin2bcd_seq;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   cyc;
    int   last_done;

    bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference built from division, independent of double-dabble.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        if (v > 9999) return 16'hFFFF;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [3:0] ref_mask(input int v);
        logic [3:0] m;
        m = 4'b0000;
        if (v > 9999) return m;
        m[3] = (v < 1000);
        m[2] = (v < 100);
        m[1] = (v < 10);
        return m;
    endfunction

    // Start a conversion in the current cycle and wait for its done pulse.
    task automatic run(input int v, input bit chk_space);
        int n;
        bus.bin_in = 14'(v);
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("latency", n, 15);
        chk("bcd_out", 32'(bus.bcd_out), 32'(ref_bcd(v)));
        chk("overflow", 32'(bus.overflow), 32'(v > 9999));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef LEADING_ZERO_MASK_EN
        chk("blank_mask", 32'(bus.blank_mask), 32'(ref_mask(v)));
`endif
        if (chk_space) chk("done_spacing", cyc - last_done, 16);
        last_done = cyc;
    endtask

    initial begin
        int n;
        int seen;
        int v;
        n_assert  = 0;
        n_fail    = 0;
        last_done = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        #22;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
`ifdef LEADING_ZERO_MASK_EN
        chk("rst_mask", 32'(bus.blank_mask), 32'b1110);
`endif
        rst_n = 1'b1;
        tick();

        run(0, 1'b0);
        run(9999, 1'b1);
        chk("max_val_bcd", 32'(bus.bcd_out), 32'h9999);
        run(10000, 1'b1);
        chk("ovf_bcd", 32'(bus.bcd_out), 32'hFFFF);
        run(16383, 1'b1);

        // start held high: bin_in changing while busy must not disturb the result
        bus.bin_in = 14'd1234;
        bus.start  = 1'b1;
        tick();
        bus.bin_in = 14'd777;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("held_latency1", n, 15);
        chk("held_bcd1", 32'(bus.bcd_out), 32'h1234);
        tick();
        bus.start = 1'b0;
        chk("held_busy2", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("held_latency2", n, 15);
        chk("held_bcd2", 32'(bus.bcd_out), 32'h0777);

        // reset in the middle of a conversion
        bus.bin_in = 14'd4321;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        repeat (5) tick();
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_bcd", 32'(bus.bcd_out), 32'd0);
        chk("abort_ovf", 32'(bus.overflow), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
        run(57, 1'b0);
        chk("after_abort_bcd", 32'(bus.bcd_out), 32'h0057);

`ifdef LEADING_ZERO_MASK_EN
        run(42, 1'b1);
        chk("mask_42", 32'(bus.blank_mask), 32'b1100);
        run(0, 1'b1);
        chk("mask_0", 32'(bus.blank_mask), 32'b1110);
        run(10000, 1'b1);
        chk("mask_ovf", 32'(bus.blank_mask), 32'b0000);
`endif

        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(16383, 0));
            run(v, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
